// File: rtl/score_keeper_if.sv
`default_nettype none
// ============================================================================
// Module      : score_keeper_if
// Description : Round-result / score-bar bundle between the game-logic round
//               FSM (master) and the score keeper (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface score_keeper_if;
    logic       round_valid;
    logic [1:0] round_winner;
    logic       new_game;
    logic [2:0] p1;
    logic [2:0] p2;
    logic       draw_en;
    logic       busy;
    logic       game_over;
    logic [1:0] winner;
    logic       dropped;

    // Game-logic side: issues round results, observes scores and status
    modport master (
        output round_valid, round_winner, new_game,
        input  p1, p2, draw_en, busy, game_over, winner, dropped
    );

    // Score keeper side
    modport slave (
        input  round_valid, round_winner, new_game,
        output p1, p2, draw_en, busy, game_over, winner, dropped
    );
endinterface
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : score_keeper
// Description : Saturating two-player scorekeeper with winner detection and a
//               fixed-length draw_en window per score change for the bar
//               drawer. Optional one-deep pending buffer for results arriving
//               mid-redraw, enabled by defining SCORE_PENDING_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module score_keeper #(
    parameter int WIN_SCORE   = 4,
    parameter int DRAW_CYCLES = 61
) (
    input  logic          clk,
    input  logic          reset,
    score_keeper_if.slave bus
);

    localparam int                 c_CNT_W   = (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DRAW_CYCLES - 1);
    localparam logic [2:0]         c_WIN     = 3'(WIN_SCORE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_p1;
    logic [2:0]         r_p2;
    logic               r_draw_en;
    logic               r_busy;
    logic               r_game_over;
    logic [1:0]         r_winner;
    logic               r_dropped;

    logic               w_win_p1;
    logic               w_win_p2;
    logic               w_cnt_last;
    logic               w_win_reached;
    logic [2:0]         w_p1_inc;
    logic [2:0]         w_p2_inc;

    assign w_win_p1      = bus.round_valid && (bus.round_winner == 2'b01);
    assign w_win_p2      = bus.round_valid && (bus.round_winner == 2'b10);
    assign w_cnt_last    = (r_cnt == c_CNT_MAX);
    assign w_win_reached = (r_p1 == c_WIN) || (r_p2 == c_WIN);
    assign w_p1_inc      = (r_p1 < c_WIN) ? (r_p1 + 3'd1) : r_p1;
    assign w_p2_inc      = (r_p2 < c_WIN) ? (r_p2 + 3'd1) : r_p2;

`ifdef SCORE_PENDING_EN
    logic       r_pend_vld;
    logic [1:0] r_pend_win;
    logic       w_rv_any;
    logic       w_sel_vld;
    logic [1:0] w_sel_win;

    // Ties are buffered too (and later consumed silently); 00 is "no result".
    assign w_rv_any  = bus.round_valid && (bus.round_winner != 2'b00);
    // At window close the buffered result is used; if the buffer is empty, a
    // result arriving on that very edge is taken directly so it is never stranded.
    assign w_sel_vld = r_pend_vld | w_rv_any;
    assign w_sel_win = r_pend_vld ? r_pend_win : bus.round_winner;
`endif

    // Scoring FSM with registered outputs; new_game overrides any round result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_p1        <= 3'd0;
            r_p2        <= 3'd0;
            r_draw_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= 2'b00;
            r_dropped   <= 1'b0;
`ifdef SCORE_PENDING_EN
            r_pend_vld  <= 1'b0;
            r_pend_win  <= 2'b00;
`endif
        end else if (bus.new_game) begin
            r_p1        <= 3'd0;
            r_p2        <= 3'd0;
            r_winner    <= 2'b00;
            r_game_over <= 1'b0;
            r_dropped   <= 1'b0;
            r_state     <= S_DRAW;
            r_cnt       <= '0;
            r_draw_en   <= 1'b1;
            r_busy      <= 1'b1;
`ifdef SCORE_PENDING_EN
            r_pend_vld  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_p1 || w_win_p2) begin
                        if (w_win_p1) r_p1 <= w_p1_inc;
                        else          r_p2 <= w_p2_inc;
                        r_state   <= S_DRAW;
                        r_cnt     <= '0;
                        r_draw_en <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end

                S_DRAW: begin
`ifdef SCORE_PENDING_EN
                    if (w_rv_any) begin
                        if (r_pend_vld) begin
                            r_dropped <= 1'b1;
                        end else begin
                            r_pend_vld <= 1'b1;
                            r_pend_win <= bus.round_winner;
                        end
                    end
`else
                    if (w_win_p1 || w_win_p2) r_dropped <= 1'b1;
`endif
                    if (w_cnt_last) begin
`ifdef SCORE_PENDING_EN
                        // Buffer is always emptied when a window closes
                        r_pend_vld <= 1'b0;
`endif
                        if (w_win_reached) begin
                            r_state     <= S_OVER;
                            r_draw_en   <= 1'b0;
                            r_game_over <= 1'b1;
                            r_winner    <= (r_p1 == c_WIN) ? 2'b01 : 2'b10;
`ifdef SCORE_PENDING_EN
                        end else if (w_sel_vld && (w_sel_win == 2'b01)) begin
                            r_p1  <= w_p1_inc;
                            r_cnt <= '0;
                        end else if (w_sel_vld && (w_sel_win == 2'b10)) begin
                            r_p2  <= w_p2_inc;
                            r_cnt <= '0;
`endif
                        end else begin
                            r_state   <= S_IDLE;
                            r_draw_en <= 1'b0;
                            r_busy    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_OVER: begin
                    // Held until new_game or reset; round results ignored
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_draw_en <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.p1        = r_p1;
    assign bus.p2        = r_p2;
    assign bus.draw_en   = r_draw_en;
    assign bus.busy      = r_busy;
    assign bus.game_over = r_game_over;
    assign bus.winner    = r_winner;
    assign bus.dropped   = r_dropped;

endmodule
`default_nettype wire

// File: doc/score_keeper.md
# score_keeper

Round-result scorekeeper and redraw sequencer for the two-player black-and-white game. Accepts one round outcome at a time and keeps saturating 3-bit scores for both players. Detects the game winner, and drives the score-bar drawer: its outputs `p1`, `p2`, `draw_en` feed the drawer's score and enable inputs directly. Sits between the game-logic round FSM and the score drawer.

## Interface
- `WIN_SCORE`, default 4: score at which a player wins; scores saturate here. Legal range 1..7.
- `DRAW_CYCLES`, default 61: length of one `draw_en` window, equal to one full drawer sweep of counts 0..60.
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `round_valid` input 1: one-cycle pulse; a round result is present.
- `round_winner` input 2: 01 = player 1 won, 10 = player 2 won, 11 = tied round, 00 = no result. Sampled only when `round_valid` = 1.
- `new_game` input 1: one-cycle pulse; clears scores and redraws.
- `p1` output 3: player 1 score.
- `p2` output 3: player 2 score.
- `draw_en` output 1: drawer enable, high for exactly `DRAW_CYCLES` consecutive cycles per redraw.
- `busy` output 1: high when the state is not IDLE.
- `game_over` output 1: high in state OVER.
- `winner` output 2: 01 or 10 once game is over, else 00.
- `dropped` output 1: sticky; a round result was lost. Cleared by `reset` or `new_game`.

## Operation
- States: IDLE, DRAW, OVER. Draw counter `cnt` is sized for `DRAW_CYCLES`-1.
- Reset values: `p1`=0, `p2`=0, `draw_en`=0, `busy`=0, `game_over`=0, `winner`=00, `dropped`=0, state=IDLE, `cnt`=0, pending buffer empty.
- Score rule:
  - 01 increments `p1`, saturating at `WIN_SCORE`.
  - 10 increments `p2`, saturating at `WIN_SCORE`.
  - 11 and 00 change nothing and trigger no redraw.
- IDLE, `round_valid` with a score-changing winner: score is updated on that edge; state goes to DRAW with `cnt`=0.
- DRAW:
  - `draw_en`=1 and `cnt` increments each cycle.
  - At `cnt`=`DRAW_CYCLES`-1, the next state is chosen in this priority order:
    1. OVER, if either score equals `WIN_SCORE`.
    2. DRAW again with `cnt`=0, if a pending result is accepted.
    3. IDLE.
- `winner` is set on entry to OVER: 01 if `p1`=`WIN_SCORE`, else 10.
- OVER:
  - `round_valid` is ignored, and `dropped` is not set.
  - Only `new_game` or `reset` leaves OVER.
- `new_game` in any state:
  - Scores, `winner`, `game_over`, `dropped` and pending are cleared.
  - State goes to DRAW with `cnt`=0, so zero-length bars are redrawn.
  - `new_game` wins over a simultaneous `round_valid`, which is discarded.
- `round_valid` while in DRAW: handling depends on `SCORE_PENDING_EN`; see Configuration.
- Scores never exceed `WIN_SCORE`, and both players can never reach it, because exactly one score changes per accepted round.

## Timing
- `round_valid` at edge t (IDLE):
  - `p1`/`p2` show the new value from cycle t+1.
  - `draw_en` is high for cycles t+1 .. t+`DRAW_CYCLES`.
- Scores are stable for the whole `draw_en` window. A pending result is applied on the edge that closes the window, so the drawer never sees a score change mid-sweep.
- Back-to-back redraws have no gap: `draw_en` stays high continuously for 2×`DRAW_CYCLES`.
- `game_over`/`winner` assert in the cycle after the final `draw_en` cycle.
- `reset` mid-DRAW: `draw_en`=0 from the next cycle and the score window is abandoned. The drawer clears its own counter on the same reset.
- `busy` is registered and equals (state != IDLE).

## Configuration
- `SCORE_PENDING_EN` defined:
  - A one-deep pending buffer holds a `round_valid` result received during DRAW.
  - A further result while the buffer is full is discarded and sets `dropped`.
  - A pending tie (11) is consumed with no redraw.
- `SCORE_PENDING_EN` undefined:
  - No buffer exists.
  - Every score-changing `round_valid` in DRAW is discarded and sets `dropped`.
  - The transition to DRAW at window end never occurs.

## Test plan
- Reset, then `round_valid` with 01 → `p1`=1 next cycle; `draw_en` high exactly 61 cycles; back to IDLE; `busy` low.
- Four player-2 wins separated by idle gaps → `p2`=4; after the 4th window `game_over`=1, `winner`=10; a further `round_valid` leaves `p2`=4 and `dropped`=0.
- `SCORE_PENDING_EN`: 01 in IDLE, then 10 and 01 during the window → second window with `p2`=1, `p1`=1, `draw_en` continuous 122 cycles, `dropped`=1. Without the macro: `p2`=0 and `dropped`=1.
- Tied round (11) in IDLE → no score change, `draw_en` stays 0.
- `new_game` during OVER with `p1`=4 → scores 0, `winner`=00, 61-cycle `draw_en` window; `new_game` and `round_valid` in the same cycle → scores 0.
- `reset` at cycle 30 of a window → `draw_en`=0 next cycle, all outputs at reset values.
